// File: rtl/vt52_video_pkg.sv
// rtl/vt52_video_pkg.sv - raster mode parameter sets and derived totals for the video path
package vt52_video_pkg;

  typedef struct packed {
    int unsigned visible;
    int unsigned fp;
    int unsigned pulse;
    int unsigned bp;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } vt_mode_t;

  // 1280x1024@60 letterboxed to 800 visible lines
  localparam vt_mode_t MODE_1280X1024_LB = '{
    h: '{visible: 1280, fp: 48, pulse: 112, bp: 248},
    v: '{visible: 800,  fp: 113, pulse: 3,  bp: 150}
  };

  localparam vt_mode_t MODE_640X480 = '{
    h: '{visible: 640, fp: 16, pulse: 96, bp: 48},
    v: '{visible: 480, fp: 10, pulse: 2,  bp: 33}
  };

  function automatic int unsigned axis_total(input int unsigned bp, input int unsigned vis,
                                             input int unsigned fp, input int unsigned pulse);
    return bp + vis + fp + pulse;
  endfunction

  function automatic int unsigned h_total(input vt_mode_t m);
    return axis_total(m.h.bp, m.h.visible, m.h.fp, m.h.pulse);
  endfunction

  function automatic int unsigned v_total(input vt_mode_t m);
    return axis_total(m.v.bp, m.v.visible, m.v.fp, m.v.pulse);
  endfunction

endpackage

// File: rtl/video_timing_gen_axis.sv
// rtl/video_timing_gen_axis.sv - one raster axis: wrapping counter plus registered region decode
module timing_axis
  import vt52_video_pkg::*;
#(
  parameter int unsigned BP    = 1,
  parameter int unsigned VIS   = 1,
  parameter int unsigned FP    = 1,
  parameter int unsigned PULSE = 1,
  parameter logic        POL   = 1'b1,
  parameter int unsigned CW    = 8
) (
  input  logic          px_clk,
  input  logic          clr_n,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic [CW-1:0] pos,
  output logic          blank,
  output logic          sync,
  output logic          wrap
);

  localparam int unsigned   TOTAL   = axis_total(BP, VIS, FP, PULSE);
  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] VIS_LO  = CW'(BP);
  localparam logic [CW-1:0] VIS_HI  = CW'(BP + VIS);
  localparam logic [CW-1:0] SYNC_LO = CW'(BP + VIS + FP);

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pos_q, pos_d;
  logic          blank_q, blank_d;
  logic          sync_q, sync_d;

  // Combinational so the next axis can step in the same cycle this one wraps
  assign wrap = step && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (step) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
    blank_d = !((count_d >= VIS_LO) && (count_d < VIS_HI));
    pos_d   = blank_d ? '0 : count_d - VIS_LO;
    sync_d  = (count_d >= SYNC_LO) ? POL : ~POL;
  end

  always_ff @(posedge px_clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= '0;
      pos_q   <= '0;
      blank_q <= 1'b1;
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      pos_q   <= pos_d;
      blank_q <= blank_d;
      sync_q  <= sync_d;
    end
  end

  assign count = count_q;
  assign pos   = pos_q;
  assign blank = blank_q;
  assign sync  = sync_q;

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - parametrised raster timing generator (pixel clock domain)
// Optional frame counter / cursor blink built only when VTG_FRAME_CNT_EN is defined.
module video_timing_gen
  import vt52_video_pkg::*;
#(
  parameter int unsigned H_VISIBLE = MODE_1280X1024_LB.h.visible,
  parameter int unsigned H_FP      = MODE_1280X1024_LB.h.fp,
  parameter int unsigned H_PULSE   = MODE_1280X1024_LB.h.pulse,
  parameter int unsigned H_BP      = MODE_1280X1024_LB.h.bp,
  parameter int unsigned V_VISIBLE = MODE_1280X1024_LB.v.visible,
  parameter int unsigned V_FP      = MODE_1280X1024_LB.v.fp,
  parameter int unsigned V_PULSE   = MODE_1280X1024_LB.v.pulse,
  parameter int unsigned V_BP      = MODE_1280X1024_LB.v.bp,
  parameter logic        HSYNC_POL = 1'b1,
  parameter logic        VSYNC_POL = 1'b1,
  parameter int unsigned CW        = 11,
  parameter int unsigned FRAME_CW  = 8,
  parameter int unsigned BLINK_BIT = 4
) (
  input  logic                px_clk,
  input  logic                clr_n,
  input  logic                en,
  output logic [CW-1:0]       hc,
  output logic [CW-1:0]       vc,
  output logic [CW-1:0]       x,
  output logic [CW-1:0]       y,
  output logic                hsync,
  output logic                vsync,
  output logic                hblank,
  output logic                vblank,
  output logic                de,
  output logic                line_start,
  output logic                frame_start,
  output logic [FRAME_CW-1:0] frame_cnt,
  output logic                blink
);

  localparam int unsigned H_TOTAL = axis_total(H_BP, H_VISIBLE, H_FP, H_PULSE);
  localparam int unsigned V_TOTAL = axis_total(V_BP, V_VISIBLE, V_FP, V_PULSE);

  generate
    if (H_VISIBLE == 0 || H_FP == 0 || H_PULSE == 0 || H_BP == 0 ||
        V_VISIBLE == 0 || V_FP == 0 || V_PULSE == 0 || V_BP == 0) begin : g_err_zero
      $error("video_timing_gen: timing parameters must be non-zero");
    end
    if ((longint'(H_TOTAL) - 1) >= (longint'(1) << CW) ||
        (longint'(V_TOTAL) - 1) >= (longint'(1) << CW)) begin : g_err_width
      $error("video_timing_gen: H_TOTAL-1 or V_TOTAL-1 does not fit in CW bits");
    end
    if (BLINK_BIT >= FRAME_CW) begin : g_err_blink
      $error("video_timing_gen: BLINK_BIT must be below FRAME_CW");
    end
  endgenerate

  logic h_wrap, v_wrap, frame_wrap;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  timing_axis #(
    .BP(H_BP), .VIS(H_VISIBLE), .FP(H_FP), .PULSE(H_PULSE), .POL(HSYNC_POL), .CW(CW)
  ) u_h_axis (
    .px_clk(px_clk), .clr_n(clr_n), .step(en),
    .count(hc), .pos(x), .blank(hblank), .sync(hsync), .wrap(h_wrap)
  );

  // h_wrap already carries en, so the vertical axis freezes with the raster
  timing_axis #(
    .BP(V_BP), .VIS(V_VISIBLE), .FP(V_FP), .PULSE(V_PULSE), .POL(VSYNC_POL), .CW(CW)
  ) u_v_axis (
    .px_clk(px_clk), .clr_n(clr_n), .step(h_wrap),
    .count(vc), .pos(y), .blank(vblank), .sync(vsync), .wrap(v_wrap)
  );

  assign frame_wrap = h_wrap && v_wrap;

  always_comb begin
    line_start_d  = h_wrap;
    frame_start_d = frame_wrap;
  end

  always_ff @(posedge px_clk or negedge clr_n) begin
    if (!clr_n) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign de          = ~hblank & ~vblank;

`ifdef VTG_FRAME_CNT_EN
  logic [FRAME_CW-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_wrap) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge px_clk or negedge clr_n) begin
    if (!clr_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign blink     = frame_cnt_q[BLINK_BIT];
`else
  assign frame_cnt = '0;
  assign blink     = 1'b0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - bench for video_timing_gen in the small 8x6 mode
module tb_video_timing_gen;

  localparam int CW = 4;
  localparam int FCW = 4;
  localparam int HT = 8;
  localparam int VT = 6;
  localparam int FT = HT * VT;

  logic px_clk = 1'b0;
  logic clr_n;
  logic en;
  logic [CW-1:0] hc, vc, x, y;
  logic hsync, vsync, hblank, vblank, de, line_start, frame_start, blink;
  logic [FCW-1:0] frame_cnt;

  int total = 0;
  int bad = 0;
  int t = 0;
  logic adv = 1'b0;

  video_timing_gen #(
    .H_VISIBLE(4), .H_FP(1), .H_PULSE(1), .H_BP(2),
    .V_VISIBLE(3), .V_FP(1), .V_PULSE(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0),
    .CW(CW), .FRAME_CW(FCW), .BLINK_BIT(1)
  ) dut (
    .px_clk(px_clk), .clr_n(clr_n), .en(en),
    .hc(hc), .vc(vc), .x(x), .y(y),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank), .de(de),
    .line_start(line_start), .frame_start(frame_start),
    .frame_cnt(frame_cnt), .blink(blink)
  );

  always #5 px_clk = ~px_clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference: t is the number of advancing edges since reset; everything follows from t.
  task automatic check_all(input string tag);
    int hce, vce, fce;
    logic hbe, vbe;
    hce = t % HT;
    vce = (t / HT) % VT;
    hbe = !(hce >= 2 && hce < 6);
    vbe = !(vce >= 1 && vce < 4);
`ifdef VTG_FRAME_CNT_EN
    fce = (t / FT) % 16;
`else
    fce = 0;
`endif
    chk({tag, ".hc"}, int'(hc), hce);
    chk({tag, ".vc"}, int'(vc), vce);
    chk({tag, ".x"}, int'(x), hbe ? 0 : hce - 2);
    chk({tag, ".y"}, int'(y), vbe ? 0 : vce - 1);
    chk({tag, ".hblank"}, int'(hblank), int'(hbe));
    chk({tag, ".vblank"}, int'(vblank), int'(vbe));
    chk({tag, ".hsync"}, int'(hsync), (hce == 7) ? 1 : 0);
    chk({tag, ".vsync"}, int'(vsync), (vce == 5) ? 0 : 1);
    chk({tag, ".de"}, int'(de), (!hbe && !vbe) ? 1 : 0);
    chk({tag, ".line_start"}, int'(line_start), (adv && hce == 0) ? 1 : 0);
    chk({tag, ".frame_start"}, int'(frame_start), (adv && (t % FT) == 0) ? 1 : 0);
    chk({tag, ".frame_cnt"}, int'(frame_cnt), fce);
    chk({tag, ".blink"}, int'(blink), (fce >> 1) & 1);
  endtask

  task automatic tick(input string tag);
    @(posedge px_clk);
    if (clr_n && en) begin
      t++;
      adv = 1'b1;
    end else begin
      adv = 1'b0;
    end
    #1;
    check_all(tag);
  endtask

  task automatic run_to(input int m);
    en = 1'b1;
    for (int i = 0; i < 2 * FT && (t % FT) != m; i++) tick("run_to");
    chk("run_to_reached", t % FT, m);
  endtask

  typedef struct {
    logic en;
    int   hc;
    logic ls;
    logic hb;
    int   x;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, de_cnt, ls_cnt, seen;
    logic b0;

    tbl[0] = '{1'b1, 1, 1'b0, 1'b1, 0};
    tbl[1] = '{1'b1, 2, 1'b0, 1'b0, 0};
    tbl[2] = '{1'b1, 3, 1'b0, 1'b0, 1};
    tbl[3] = '{1'b0, 3, 1'b0, 1'b0, 1};
    tbl[4] = '{1'b1, 4, 1'b0, 1'b0, 2};
    tbl[5] = '{1'b1, 5, 1'b0, 1'b0, 3};
    tbl[6] = '{1'b1, 6, 1'b0, 1'b1, 0};
    tbl[7] = '{1'b1, 7, 1'b0, 1'b1, 0};
    tbl[8] = '{1'b1, 0, 1'b1, 1'b1, 0};
    tbl[9] = '{1'b1, 1, 1'b0, 1'b1, 0};

    clr_n = 1'b0;
    en = 1'b0;
    repeat (3) tick("reset");
    clr_n = 1'b1;
    #2;
    check_all("released");

    for (int i = 0; i < 10; i++) begin
      en = tbl[i].en;
      tick("table");
      chk($sformatf("tbl%0d.hc", i), int'(hc), tbl[i].hc);
      chk($sformatf("tbl%0d.line_start", i), int'(line_start), int'(tbl[i].ls));
      chk($sformatf("tbl%0d.hblank", i), int'(hblank), int'(tbl[i].hb));
      chk($sformatf("tbl%0d.x", i), int'(x), tbl[i].x);
    end

    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 3) != 0);
      tick("random");
    end

    // Full frame at en=1: 48 edges, 12 de cycles, 6 line strobes
    run_to(0);
    cnt = 0; de_cnt = 0; ls_cnt = 0; seen = 0;
    for (int i = 0; i < 120 && !seen; i++) begin
      tick("frame");
      cnt++;
      de_cnt += int'(de);
      ls_cnt += int'(line_start);
      if (frame_start) seen = 1;
    end
    chk("frame_seen", seen, 1);
    chk("frame_len", cnt, FT);
    chk("frame_de_cycles", de_cnt, 12);
    chk("frame_line_starts", ls_cnt, 6);

    // Freeze for 5 cycles at hc=3, vc=2
    run_to(0);
    cnt = 0; seen = 0;
    en = 1'b1;
    for (int i = 0; i < 19; i++) begin
      tick("pre_freeze");
      cnt++;
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick("freeze");
      cnt++;
      chk("freeze.hc", int'(hc), 3);
      chk("freeze.vc", int'(vc), 2);
    end
    en = 1'b1;
    for (int i = 0; i < 120 && !seen; i++) begin
      tick("post_freeze");
      cnt++;
      if (frame_start) seen = 1;
    end
    chk("frozen_frame_seen", seen, 1);
    chk("frozen_frame_len", cnt, FT + 5);

`ifdef VTG_FRAME_CNT_EN
    run_to(0);
    b0 = blink;
    for (int i = 0; i < 250 && blink == b0; i++) tick("blink_a");
    b0 = blink;
    cnt = 0;
    for (int i = 0; i < 250 && blink == b0; i++) begin
      tick("blink_b");
      cnt++;
    end
    chk("blink_period", cnt, 2 * FT);
`else
    b0 = 1'b0;
    for (int i = 0; i < 2 * FT; i++) begin
      tick("noblink");
      b0 = b0 | blink | (|frame_cnt);
    end
    chk("no_frame_counter", int'(b0), 0);
`endif

    // Asynchronous reset mid-line at hc=6, vc=4
    run_to(38);
    chk("pre_rst.hc", int'(hc), 6);
    chk("pre_rst.vc", int'(vc), 4);
    #2;
    clr_n = 1'b0;
    #1;
    t = 0;
    adv = 1'b0;
    check_all("async_rst");
    tick("rst_held");
    clr_n = 1'b1;
    #2;
    check_all("rst_released");
    tick("restart");
    chk("restart.hc", int'(hc), 1);
    chk("restart.vc", int'(vc), 0);
    for (int i = 0; i < 60; i++) tick("after_restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the terminal's video path, the successor to the fixed 1280x1024 sync generator. It runs in the pixel clock domain. It produces hsync/vsync, blanking, data-enable, raw and visible-area coordinates, line/frame start strobes and an optional cursor-blink frame counter. The PLL is outside this block: the pixel clock arrives as an input, so the block can be reused for any mode.

## Interface
- H_VISIBLE, 1280: visible pixels per line
- H_FP, 48: horizontal front porch
- H_PULSE, 112: hsync pulse width
- H_BP, 248: horizontal back porch
- V_VISIBLE, 800: visible lines
- V_FP, 113: vertical front porch
- V_PULSE, 3: vsync pulse width
- V_BP, 150: vertical back porch
- HSYNC_POL, 1'b1: active level of hsync
- VSYNC_POL, 1'b1: active level of vsync
- CW, 11: coordinate/counter width
- FRAME_CW, 8: frame counter width
- BLINK_BIT, 4: frame_cnt bit that drives blink
- px_clk  in  1  pixel clock, the single clock
- clr_n  in  1  reset, asynchronous, active-low
- en  in  1  advance counters; low freezes the raster
- hc  out  CW  raw horizontal count
- vc  out  CW  raw vertical count
- x  out  CW  visible-area column (hc-H_BP), 0 outside visible area
- y  out  CW  visible-area row (vc-V_BP), 0 outside visible area
- hsync, vsync  out  1  sync outputs at configured polarity
- hblank, vblank  out  1  blanking flags (1 = blanked)
- de  out  1  ~hblank & ~vblank
- line_start  out  1  one-cycle strobe on horizontal wrap
- frame_start  out  1  one-cycle strobe on frame wrap
- frame_cnt  out  FRAME_CW  frames completed (only with VTG_FRAME_CNT_EN)
- blink  out  1  frame_cnt[BLINK_BIT] (only with VTG_FRAME_CNT_EN)

## Operation
- H_TOTAL = H_BP+H_VISIBLE+H_FP+H_PULSE.
- Horizontal region order: back porch [0,H_BP), visible [H_BP,H_BP+H_VISIBLE), front porch, then sync pulse in the last H_PULSE counts. The vertical axis uses the same order.
- hc counts 0..H_TOTAL-1 and wraps to 0. This fixes the old generator, which counted H_TOTAL+1 states. vc increments only when hc wraps, counts 0..V_TOTAL-1, and wraps to 0.
- en=0: hc, vc and all level outputs hold; line_start, frame_start and the frame counter do not change (strobes 0).
- line_start=1 in the cycle hc==0 following a wrap. frame_start=1 when both wrap together (hc==0 && vc==0).
- Strobes are not asserted on the first cycle after reset release.
- Sync outputs are HSYNC_POL/VSYNC_POL when in the pulse region, and the inverse otherwise.

## Timing
- All outputs are registered. They are decoded from the next-state counters, so every output is coherent with the hc/vc value of the same cycle. Latency from counter to decode is 0 cycles.
- Reset values: hc=0, vc=0, x=0, y=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, hblank=1, vblank=1, de=0, line_start=0, frame_start=0, frame_cnt=0, blink=0.
- Reset asserted mid-line returns all outputs to their reset values immediately (asynchronously). After release, counting restarts at (0,0) on the first en=1 edge.
- Elaboration errors:
  - any timing parameter is 0;
  - H_TOTAL-1 or V_TOTAL-1 does not fit in CW bits;
  - BLINK_BIT >= FRAME_CW.

## Configuration
- VTG_FRAME_CNT_EN defined: frame_cnt increments by 1 on each frame_start (wrapping at 2^FRAME_CW), and blink = frame_cnt[BLINK_BIT].
- VTG_FRAME_CNT_EN undefined: the frame counter is not built, and frame_cnt and blink are tied to 0. The port list is unchanged.

## Structure
- Shared package vt52_video_pkg holds:
  - the timing parameter sets for the supported modes (1280x1024@60 letterboxed to 800 lines; 640x480@60);
  - the derived H_TOTAL/V_TOTAL functions.
- Natural sub-module: timing_axis, instantiated twice (horizontal, vertical). Its parameters are BP/VIS/FP/PULSE/POL/CW. Its ports are inputs px_clk, clr_n, step, and outputs count, pos, blank, sync, wrap.
- The vertical instance's step is the horizontal wrap gated by en.

## Test plan
- Small mode H=2/4/1/1 (total 8), V=1/3/1/1 (total 6), en=1: hc runs 0..7, then 0; hblank=0 exactly for hc 2..5; hsync active only at hc=7; the full frame is 48 cycles.
- Same mode: de high for 12 cycles per frame; x runs 0..3 at hc 2..5; y runs 0..2 at vc 1..3; x=y=0 elsewhere.
- Strobes: line_start fires every 8 cycles; frame_start fires only at cycle 48; neither fires right after reset release.
- en toggled low for 5 cycles at hc=3, vc=2: all outputs frozen for 5 cycles; the frame then takes 53 cycles total.
- clr_n pulsed low at hc=6, vc=4: outputs immediately take their reset values; after release, counting restarts at (0,0).
- With VTG_FRAME_CNT_EN, BLINK_BIT=1: blink toggles every 2 frames (96 cycles). Without the macro, frame_cnt=0 and blink=0 throughout.
